seq_alu_disp: RTL and testbench

Parametrised, multi-cycle successor to the combinational ALU-plus-display top level. It accepts two unsigned WIDTH-bit operands on a start/busy/done handshake. It computes add, subtract, shift-add multiply or restoring divide, then converts the result to BCD with a sequential double-dabble. It drives DIGITS active-low seven-segment digits, and all outputs update together on the done cycle.

---
 rtl/seq_alu_disp.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_seq_alu_disp.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu_disp.sv
// seq_alu_disp
//   Multi-cycle ALU with seven-segment display output. An operation is
//   requested with start while the block is idle. The block computes add,
//   subtract, shift-add multiply or restoring divide. It then converts the
//   displayable value to BCD with a sequential double-dabble. The result,
//   the error flag and the segment pattern are presented together on the
//   done cycle.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy=0
//   a, b   in   WIDTH-bit unsigned operands
//   func   in   opcode: 000 add, 001 sub, 010 mul, 011 div, 1xx reserved
//   busy   out  high from the accepting edge through the done cycle
//   done   out  one-cycle pulse when out/err/seg carry a new result
//   out    out  2*WIDTH-bit registered result
//   err    out  registered error / negative-difference flag
//   seg    out  DIGITS active-low digits, digit i at seg[7i+6:7i], {g..a}
module seq_alu_disp #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [2:0]            func,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    out,
    output logic                  err,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int RW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(RW + 1);

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_MUL = 3'b010;
    localparam logic [2:0] F_DIV = 3'b011;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Largest value that fits on the display; anything above shows dashes.
    localparam longint unsigned DISP_MAX = pow10(DIGITS) - 1;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Leading zeros blank from the top down; digit 0 always shows.
    function automatic logic [SW-1:0] seg_encode(input logic [BW-1:0] bcd,
                                                 input logic          dash);
        logic [SW-1:0] s;
        logic          lead;
        s    = '1;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (dash) begin
                s[7*i +: 7] = SEG_DASH;
            end else if (lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
                s[7*i +: 7] = SEG_BLANK;
            end else begin
                lead        = 1'b0;
                s[7*i +: 7] = seg_digit(bcd[4*i +: 4]);
            end
        end
        return s;
    endfunction

    localparam logic [SW-1:0] SEG_RST = seg_encode('0, 1'b0);

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before a shift.
    function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] bcd);
        logic [BW-1:0] r;
        r = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_CONV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;

    // Operation registers (loaded on accept, no reset needed).
    logic [2:0]       func_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [RW-1:0]    acc_r, mcand_r;
    logic [WIDTH-1:0] mplier_r, rem_r, quot_r;
    logic [RW-1:0]    res_r;
    logic             err_r, dash_r;
    logic [RW-1:0]    sh_r;
    logic [BW-1:0]    bcd_r;

    logic [CW-1:0]    calc_len;
    logic             calc_last, conv_last;

    logic [RW-1:0]    mul_acc_nxt;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt, quot_nxt;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] absdiff;
    logic [RW-1:0]    res_nxt, disp_nxt;
    logic             err_nxt, dash_nxt;

    logic [BW+RW-1:0] dd_cat;
    logic [BW-1:0]    bcd_nxt;
    logic [RW-1:0]    sh_nxt;

    assign calc_len  = ((func_r == F_MUL) || (func_r == F_DIV)) ? CW'(WIDTH) : CW'(1);
    assign calc_last = (cnt_q == calc_len - CW'(1));
    assign conv_last = (cnt_q == CW'(RW - 1));

    // Shift-add multiply step, LSB of the multiplier first.
    assign mul_acc_nxt = acc_r + (mplier_r[0] ? mcand_r : '0);

    // Restoring divide step: bring down the next dividend bit (MSB first),
    // subtract the divisor only when it fits.
    assign rem_sh   = {rem_r, quot_r[WIDTH-1]};
    assign div_ge   = (rem_sh >= {1'b0, b_r});
    assign rem_nxt  = div_ge ? WIDTH'(rem_sh - {1'b0, b_r}) : rem_sh[WIDTH-1:0];
    assign quot_nxt = {quot_r[WIDTH-2:0], div_ge};

    assign sum     = {1'b0, a_r} + {1'b0, b_r};
    assign absdiff = (a_r < b_r) ? (b_r - a_r) : (a_r - b_r);

    always_comb begin
        res_nxt  = '0;
        err_nxt  = 1'b0;
        dash_nxt = 1'b0;
        case (func_r)
            F_ADD: res_nxt = RW'(sum);
            F_SUB: begin
                res_nxt = RW'(absdiff);
                err_nxt = (a_r < b_r);
            end
            F_MUL: res_nxt = mul_acc_nxt;
            F_DIV: begin
                if (b_r == '0) begin
                    res_nxt  = '1;
                    err_nxt  = 1'b1;
                    dash_nxt = 1'b1;
                end else begin
                    res_nxt = {rem_nxt, quot_nxt};
                end
            end
            default: begin
                err_nxt  = 1'b1;
                dash_nxt = 1'b1;
            end
        endcase
        // A successful divide displays only the quotient.
        disp_nxt = (func_r == F_DIV) ? RW'(quot_nxt) : res_nxt;
        if (64'(disp_nxt) > DISP_MAX) dash_nxt = 1'b1;
    end

    assign dd_cat  = {dabble_adj(bcd_r), sh_r} << 1;
    assign bcd_nxt = dd_cat[RW +: BW];
    assign sh_nxt  = dd_cat[RW-1:0];

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (calc_last) state_d = S_CONV;
            end
            S_CONV: begin
                busy = 1'b1;
                if (conv_last) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out     <= '0;
            err     <= 1'b0;
            seg     <= SEG_RST;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if ((state_q == S_CALC) || (state_q == S_CONV)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            // The final BCD shift and the output load share this edge.
            if ((state_q == S_CONV) && conv_last) begin
                out <= res_r;
                err <= err_r;
                seg <= seg_encode(bcd_nxt, dash_r);
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_r      <= a;
                    b_r      <= b;
                    func_r   <= func;
                    acc_r    <= '0;
                    mcand_r  <= RW'(a);
                    mplier_r <= b;
                    rem_r    <= '0;
                    quot_r   <= a;
                end
            end
            S_CALC: begin
                if (func_r == F_MUL) begin
                    acc_r    <= mul_acc_nxt;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                end
                // Divide by zero skips the iterations but keeps the timing.
                if ((func_r == F_DIV) && (b_r != '0)) begin
                    rem_r  <= rem_nxt;
                    quot_r <= quot_nxt;
                end
                if (calc_last) begin
                    res_r  <= res_nxt;
                    err_r  <= err_nxt;
                    dash_r <= dash_nxt;
                    sh_r   <= disp_nxt;
                    bcd_r  <= '0;
                end
            end
            S_CONV: begin
                sh_r  <= sh_nxt;
                bcd_r <= bcd_nxt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_alu_disp.sv
// tb_seq_alu_disp
//   Directed vectors for seq_alu_disp at WIDTH=6 and WIDTH=8 (DIGITS=4),
//   with hand-computed results, segment patterns and latencies.
module tb_seq_alu_disp;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] MUL = 3'b010;
    localparam logic [2:0] DIV = 3'b011;
    localparam logic [2:0] RSV = 3'b100;

    localparam logic [27:0] SEG_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] SEG_DASH4 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};

    logic        clk;
    logic        rst_n;

    logic        start6, busy6, done6, err6;
    logic [5:0]  a6, b6;
    logic [2:0]  func6;
    logic [11:0] out6;
    logic [27:0] seg6;

    logic        start8, busy8, done8, err8;
    logic [7:0]  a8, b8;
    logic [2:0]  func8;
    logic [15:0] out8;
    logic [27:0] seg8;

    int n_vec = 0;
    int n_err = 0;

    seq_alu_disp #(.WIDTH(6), .DIGITS(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .a(a6), .b(b6), .func(func6),
        .busy(busy6), .done(done6), .out(out6), .err(err6), .seg(seg6)
    );

    seq_alu_disp #(.WIDTH(8), .DIGITS(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .func(func8),
        .busy(busy8), .done(done8), .out(out8), .err(err8), .seg(seg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation on the WIDTH=6 instance and check its outcome.
    task automatic run6(input logic [5:0] ta, input logic [5:0] tb_v, input logic [2:0] tf,
                        input int exp_lat, input logic [11:0] exp_out, input logic exp_err,
                        input logic [27:0] exp_seg, input bit poke, input string tag);
        int cyc;
        bit seen;
        int stray;
        a6 = ta; b6 = tb_v; func6 = tf; start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        a6 = ~ta; b6 = ~tb_v; func6 = 3'b111;
        chk({tag, "_busy_on"}, 64'(busy6), 64'(1'b1));
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            start6 = (poke && (cyc == 3 || cyc == 10)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (done6) seen = 1;
        end
        start6 = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_out"}, 64'(out6), 64'(exp_out));
        chk({tag, "_err"}, 64'(err6), 64'(exp_err));
        chk({tag, "_seg"}, 64'(seg6), 64'(exp_seg));
        chk({tag, "_busy_done"}, 64'(busy6), 64'(1'b1));
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, 64'(done6), 64'(1'b0));
        chk({tag, "_busy_clr"}, 64'(busy6), 64'(1'b0));
        if (poke) begin
            stray = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (busy6 || done6) stray++;
            end
            chk({tag, "_no_queue"}, 64'(stray), 64'(0));
            chk({tag, "_hold"}, 64'(out6), 64'(exp_out));
        end
    endtask

    initial begin
        int cyc;
        int stray;
        rst_n = 1'b0;
        start6 = 1'b0; a6 = '0; b6 = '0; func6 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; func8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy6), 64'(1'b0));
        chk("rst_done", 64'(done6), 64'(1'b0));
        chk("rst_out", 64'(out6), 64'(0));
        chk("rst_err", 64'(err6), 64'(1'b0));
        chk("rst_seg", 64'(seg6), 64'(SEG_ZERO));
        chk("rst_seg8", 64'(seg8), 64'(SEG_ZERO));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run6(6'd45, 6'd27, ADD, 13, 12'd72, 1'b0, {7'h7F, 7'h7F, 7'h78, 7'h24}, 0, "add");
        run6(6'd50, 6'd50, ADD, 13, 12'd100, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}, 0, "add100");
        run6(6'd63, 6'd63, MUL, 18, 12'd3969, 1'b0, {7'h30, 7'h10, 7'h02, 7'h10}, 1, "mul");
        run6(6'd50, 6'd7, DIV, 18, 12'd71, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 0, "div");
        run6(6'd50, 6'd0, DIV, 18, 12'hFFF, 1'b1, SEG_DASH4, 0, "div0");
        run6(6'd5, 6'd9, SUB, 13, 12'd4, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h19}, 0, "sub");

        // Asynchronous reset while a multiply is in its conversion phase.
        a6 = 6'd63; b6 = 6'd63; func6 = MUL; start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy6), 64'(1'b0));
        chk("arst_done", 64'(done6), 64'(1'b0));
        chk("arst_out", 64'(out6), 64'(0));
        chk("arst_err", 64'(err6), 64'(1'b0));
        chk("arst_seg", 64'(seg6), 64'(SEG_ZERO));
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy6 || done6) stray++;
        end
        chk("arst_no_stale", 64'(stray), 64'(0));
        chk("arst_out_hold", 64'(out6), 64'(0));
        run6(6'd45, 6'd27, ADD, 13, 12'd72, 1'b0, {7'h7F, 7'h7F, 7'h78, 7'h24}, 0, "post_rst_add");

        run6(6'd5, 6'd9, RSV, 13, 12'd0, 1'b1, SEG_DASH4, 0, "rsv");

        // WIDTH=8 product exceeds four digits.
        a8 = 8'd255; b8 = 8'd255; func8 = MUL; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'd1; b8 = 8'd1; func8 = ADD;
        chk("w8_busy_on", 64'(busy8), 64'(1'b1));
        cyc = 0;
        while (!done8 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w8_latency", 64'(cyc), 64'(24));
        chk("w8_out", 64'(out8), 64'(16'd65025));
        chk("w8_err", 64'(err8), 64'(1'b0));
        chk("w8_seg", 64'(seg8), 64'(SEG_DASH4));
        @(posedge clk); #1;
        chk("w8_done_clr", 64'(done8), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
